// File: rtl/vp_ctrl_pkg.sv
// Shared constants, response codes, FSM state types and the byte-strobe merge helper
// for the vector-processor control register block.
package vp_ctrl_pkg;

    localparam int REG_W = 32;

    localparam logic [5:0] ADDR_CTRL   = 6'h00;
    localparam logic [5:0] ADDR_STATUS = 6'h04;
    localparam logic [5:0] ADDR_SRC    = 6'h08;
    localparam logic [5:0] ADDR_LEN    = 6'h0C;

    // Registers decode on addr[3:2]; these are the matching word indices.
    localparam logic [1:0] IDX_CTRL   = ADDR_CTRL[3:2];
    localparam logic [1:0] IDX_STATUS = ADDR_STATUS[3:2];
    localparam logic [1:0] IDX_SRC    = ADDR_SRC[3:2];
    localparam logic [1:0] IDX_LEN    = ADDR_LEN[3:2];

    localparam int CTRL_START     = 0;
    localparam int CTRL_IRQ_EN    = 1;
    localparam int STAT_BUSY      = 0;
    localparam int STAT_DONE      = 1;
    localparam int STAT_START_ERR = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_COMMIT = 2'd1,
        W_RESP   = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    function automatic logic [REG_W-1:0] apply_wstrb(
        input logic [REG_W-1:0] old_val,
        input logic [REG_W-1:0] new_val,
        input logic [3:0]       strb
    );
        logic [REG_W-1:0] merged;
        merged = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/vp_ctrl_regfile.sv
// Control/status register file: byte-strobed storage, start pulse generation,
// sticky W1C status bits, registered interrupt and the combinational read mux.
module vp_ctrl_regfile
    import vp_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wr_en,
    input  logic [1:0]  i_wr_idx,
    input  logic [31:0] i_wr_data,
    input  logic [3:0]  i_wr_strb,
    input  logic [1:0]  i_rd_idx,
    output logic [31:0] o_rd_data,
    input  logic        i_vp_busy,
    input  logic        i_vp_done,
    output logic        o_vp_start,
    output logic [31:0] o_vp_src_addr,
    output logic [15:0] o_vp_len,
    output logic        o_irq
);

    logic        r_irq_en;
    logic        r_done;
    logic        r_start_err;
    logic        r_vp_start;
    logic        r_irq;
    logic [31:0] r_src;
    logic [31:0] r_len;

    logic w_byte0;
    logic w_wr_ctrl;
    logic w_wr_status;
    logic w_wr_src;
    logic w_wr_len;
    logic w_start_req;
    logic w_done_clr;
    logic w_err_clr;

    // START and the W1C bits live in byte 0, so they only act when that lane is strobed.
    assign w_byte0     = i_wr_strb[0];
    assign w_wr_ctrl   = i_wr_en && (i_wr_idx == IDX_CTRL);
    assign w_wr_status = i_wr_en && (i_wr_idx == IDX_STATUS);
    assign w_wr_src    = i_wr_en && (i_wr_idx == IDX_SRC);
    assign w_wr_len    = i_wr_en && (i_wr_idx == IDX_LEN);
    assign w_start_req = w_wr_ctrl && w_byte0 && i_wr_data[CTRL_START];
    assign w_done_clr  = w_wr_status && w_byte0 && i_wr_data[STAT_DONE];
    assign w_err_clr   = w_wr_status && w_byte0 && i_wr_data[STAT_START_ERR];

    // NOTE: state uses non-blocking assignments under an async active-low reset so every
    // register samples pre-edge values and clears immediately when reset asserts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_irq_en    <= 1'b0;
            r_done      <= 1'b0;
            r_start_err <= 1'b0;
            r_vp_start  <= 1'b0;
            r_irq       <= 1'b0;
            r_src       <= '0;
            r_len       <= '0;
        end else begin
            r_vp_start <= w_start_req && !i_vp_busy;
            r_irq      <= r_done && r_irq_en;

            if (w_wr_ctrl && w_byte0) begin
                r_irq_en <= i_wr_data[CTRL_IRQ_EN];
            end
            if (w_wr_src) begin
                r_src <= apply_wstrb(r_src, i_wr_data, i_wr_strb);
            end
            if (w_wr_len) begin
                r_len <= apply_wstrb(r_len, i_wr_data, i_wr_strb);
            end

            // A done pulse coinciding with a W1C must not be lost: set beats clear.
            if (i_vp_done) begin
                r_done <= 1'b1;
            end else if (w_done_clr) begin
                r_done <= 1'b0;
            end

            if (w_start_req && i_vp_busy) begin
                r_start_err <= 1'b1;
            end else if (w_err_clr) begin
                r_start_err <= 1'b0;
            end
        end
    end

    // NOTE: the output is given a default before the case so no path leaves it unassigned,
    // which keeps this block purely combinational (no latch).
    always_comb begin
        o_rd_data = '0;
        case (i_rd_idx)
            IDX_CTRL: begin
                o_rd_data[CTRL_IRQ_EN] = r_irq_en;
            end
            IDX_STATUS: begin
                o_rd_data[STAT_BUSY]      = i_vp_busy;
                o_rd_data[STAT_DONE]      = r_done;
                o_rd_data[STAT_START_ERR] = r_start_err;
            end
            IDX_SRC:  o_rd_data = r_src;
            IDX_LEN:  o_rd_data = r_len;
            default:  o_rd_data = '0;
        endcase
    end

    assign o_vp_start    = r_vp_start;
    assign o_vp_src_addr = r_src;
    assign o_vp_len      = r_len[15:0];
    assign o_irq         = r_irq;

endmodule

// File: rtl/vp_ctrl_axil_slave.sv
// AXI4-Lite slave front end for the vector-processor control block: independent write
// (AW/W latch, commit, response) and read (capture, data) state machines around the regfile.
module vp_ctrl_axil_slave
    import vp_ctrl_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
)(
    input  logic                            ACLK,
    input  logic                            ARESETN,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,

    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,

    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,

    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,

    output logic                            vp_start,
    output logic [31:0]                     vp_src_addr,
    output logic [15:0]                     vp_len,
    input  logic                            vp_busy,
    input  logic                            vp_done,
    output logic                            irq
);

    wr_state_t   r_wr_state;
    rd_state_t   r_rd_state;

    logic        r_awready;
    logic        r_wready;
    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic        r_aw_latched;
    logic        r_w_latched;
    logic [3:0]  r_awaddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;

    logic        r_arready;
    logic        r_rvalid;
    logic [1:0]  r_rresp;
    logic [31:0] r_rdata;

    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_ar_hs;
    logic        w_wr_mapped;
    logic        w_rd_mapped;
    logic        w_commit;
    logic [31:0] w_rd_data;
    logic        w_unused_ok;

    // Ready flags are only ever high in the idle states, so these are full handshakes.
    assign w_aw_hs = r_awready && S_AXI_AWVALID;
    assign w_w_hs  = r_wready  && S_AXI_WVALID;
    assign w_ar_hs = r_arready && S_AXI_ARVALID;

    // r_awaddr holds addr[5:2]; anything in addr[5:4] lies outside the register window.
    assign w_wr_mapped = (r_awaddr[3:2] == 2'b00);
    assign w_rd_mapped = (S_AXI_ARADDR[5:4] == 2'b00);
    assign w_commit    = (r_wr_state == W_COMMIT);

    assign w_unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wr_state   <= W_IDLE;
            r_awready    <= 1'b0;
            r_wready     <= 1'b0;
            r_bvalid     <= 1'b0;
            r_bresp      <= RESP_OKAY;
            r_aw_latched <= 1'b0;
            r_w_latched  <= 1'b0;
            r_awaddr     <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    r_awready <= !(r_aw_latched || w_aw_hs);
                    r_wready  <= !(r_w_latched  || w_w_hs);
                    if (w_aw_hs) begin
                        r_awaddr     <= S_AXI_AWADDR[5:2];
                        r_aw_latched <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wdata     <= S_AXI_WDATA;
                        r_wstrb     <= S_AXI_WSTRB;
                        r_w_latched <= 1'b1;
                    end
                    if ((r_aw_latched || w_aw_hs) && (r_w_latched || w_w_hs)) begin
                        r_wr_state <= W_COMMIT;
                    end
                end
                W_COMMIT: begin
                    r_bresp      <= w_wr_mapped ? RESP_OKAY : RESP_SLVERR;
                    r_bvalid     <= 1'b1;
                    r_aw_latched <= 1'b0;
                    r_w_latched  <= 1'b0;
                    r_wr_state   <= W_RESP;
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        r_bvalid   <= 1'b0;
                        r_awready  <= 1'b1;
                        r_wready   <= 1'b1;
                        r_wr_state <= W_IDLE;
                    end
                end
                default: begin
                    r_wr_state <= W_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rd_state <= R_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rresp    <= RESP_OKAY;
            r_rdata    <= '0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rdata    <= w_rd_mapped ? w_rd_data : '0;
                        r_rresp    <= w_rd_mapped ? RESP_OKAY : RESP_SLVERR;
                        r_rvalid   <= 1'b1;
                        r_arready  <= 1'b0;
                        r_rd_state <= R_DATA;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        r_rvalid   <= 1'b0;
                        r_arready  <= 1'b1;
                        r_rd_state <= R_IDLE;
                    end
                end
                default: begin
                    r_rd_state <= R_IDLE;
                end
            endcase
        end
    end

    vp_ctrl_regfile u_regfile (
        .i_clk         (ACLK),
        .i_rst_n       (ARESETN),
        .i_wr_en       (w_commit && w_wr_mapped),
        .i_wr_idx      (r_awaddr[1:0]),
        .i_wr_data     (r_wdata),
        .i_wr_strb     (r_wstrb),
        .i_rd_idx      (S_AXI_ARADDR[3:2]),
        .o_rd_data     (w_rd_data),
        .i_vp_busy     (vp_busy),
        .i_vp_done     (vp_done),
        .o_vp_start    (vp_start),
        .o_vp_src_addr (vp_src_addr),
        .o_vp_len      (vp_len),
        .o_irq         (irq)
    );

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RDATA   = r_rdata;

endmodule

// File: tb/tb_vp_ctrl_axil_slave.sv
// Self-checking bench for vp_ctrl_axil_slave: directed register scenarios, then randomized
// AXI4-Lite traffic compared against a register-level reference model.
module tb_vp_ctrl_axil_slave;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [5:0]  S_AXI_AWADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [5:0]  S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_ARPROT = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic        vp_start;
    logic [31:0] vp_src_addr;
    logic [15:0] vp_len;
    logic        vp_busy = 1'b0;
    logic        vp_done = 1'b0;
    logic        irq;

    vp_ctrl_axil_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (6)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .vp_start      (vp_start),
        .vp_src_addr   (vp_src_addr),
        .vp_len        (vp_len),
        .vp_busy       (vp_busy),
        .vp_done       (vp_done),
        .irq           (irq)
    );

    always #5 ACLK = ~ACLK;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the architectural register contents.
    bit          m_irq_en;
    bit          m_done;
    bit          m_start_err;
    logic [31:0] m_src;
    logic [31:0] m_len;
    int          m_starts = 0;
    int          start_cnt = 0;

    always @(posedge ACLK) begin
        if (vp_start === 1'b1) start_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_irq_en    = 1'b0;
        m_done      = 1'b0;
        m_start_err = 1'b0;
        m_src       = '0;
        m_len       = '0;
    endtask

    function automatic logic [31:0] model_read(input logic [5:0] a);
        if (a[5:4] != 2'b00) return 32'h0;
        case (a[3:2])
            2'd0:    return {30'h0, m_irq_en, 1'b0};
            2'd1:    return {29'h0, m_start_err, m_done, vp_busy};
            2'd2:    return m_src;
            default: return m_len;
        endcase
    endfunction

    task automatic model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        if (a[5:4] != 2'b00) return;
        case (a[3:2])
            2'd0: begin
                if (s[0]) begin
                    m_irq_en = d[1];
                    if (d[0]) begin
                        if (vp_busy) m_start_err = 1'b1;
                        else m_starts++;
                    end
                end
            end
            2'd1: begin
                if (s[0] && d[1]) m_done = 1'b0;
                if (s[0] && d[2]) m_start_err = 1'b0;
            end
            2'd2: for (int b = 0; b < 4; b++) if (s[b]) m_src[8*b +: 8] = d[8*b +: 8];
            default: for (int b = 0; b < 4; b++) if (s[b]) m_len[8*b +: 8] = d[8*b +: 8];
        endcase
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly,
                             input logic [1:0] exp_resp);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        int k = 0;
        int lat = 0;
        while (!(aw_done && w_done) && k < 64) begin
            @(negedge ACLK);
            S_AXI_AWADDR  = a;
            S_AXI_WDATA   = d;
            S_AXI_WSTRB   = s;
            S_AXI_AWVALID = !aw_done && (k >= aw_dly);
            S_AXI_WVALID  = !w_done && (k >= w_dly);
            if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1'b1;
            if (S_AXI_WVALID && S_AXI_WREADY) w_done = 1'b1;
            k++;
        end
        if (!(aw_done && w_done)) begin
            check("wr_handshake_timeout", 32'(k), 32'(0));
            S_AXI_AWVALID = 1'b0;
            S_AXI_WVALID  = 1'b0;
            return;
        end
        do begin
            @(negedge ACLK);
            S_AXI_AWVALID = 1'b0;
            S_AXI_WVALID  = 1'b0;
            lat++;
        end while (!S_AXI_BVALID && lat < 64);
        check("bvalid_latency", 32'(lat), 32'(2));
        check("bresp", 32'(S_AXI_BRESP), 32'(exp_resp));
        if (b_dly > 0) begin
            repeat (b_dly) @(negedge ACLK);
            check("bvalid_hold", 32'(S_AXI_BVALID), 32'(1));
        end
        S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_BREADY = 1'b0;
        check("bvalid_drop", 32'(S_AXI_BVALID), 32'(0));
    endtask

    task automatic axi_read(input logic [5:0] a, input int r_dly,
                            output logic [31:0] data, output logic [1:0] resp);
        int k = 0;
        data = '0;
        resp = '0;
        @(negedge ACLK);
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        while (!S_AXI_ARREADY && k < 64) begin
            @(negedge ACLK);
            k++;
        end
        if (!S_AXI_ARREADY) begin
            check("arready_timeout", 32'(k), 32'(0));
            S_AXI_ARVALID = 1'b0;
            return;
        end
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
        check("rvalid_latency", 32'(S_AXI_RVALID), 32'(1));
        repeat (r_dly) @(negedge ACLK);
        data = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_RREADY = 1'b0;
        check("rvalid_drop", 32'(S_AXI_RVALID), 32'(0));
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_src"}, vp_src_addr, m_src);
        check({tag, "_len"}, 32'(vp_len), 32'(m_len[15:0]));
        check({tag, "_starts"}, start_cnt, m_starts);
        check({tag, "_irq"}, 32'(irq), 32'(m_irq_en & m_done));
    endtask

    task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly);
        logic [1:0] exp_resp;
        exp_resp = (a[5:4] == 2'b00) ? 2'b00 : 2'b10;
        model_write(a, d, s);
        axi_write(a, d, s, aw_dly, w_dly, b_dly, exp_resp);
        check_outputs("wr");
    endtask

    task automatic do_read(input logic [5:0] a, input int r_dly);
        logic [31:0] d;
        logic [1:0]  r;
        logic [31:0] exp_d;
        exp_d = model_read(a);
        axi_read(a, r_dly, d, r);
        check($sformatf("rdata_%02h", a), d, exp_d);
        check($sformatf("rresp_%02h", a), 32'(r), (a[5:4] == 2'b00) ? 32'h0 : 32'h2);
    endtask

    task automatic pulse_done();
        @(negedge ACLK);
        vp_done = 1'b1;
        @(negedge ACLK);
        vp_done = 1'b0;
        m_done  = 1'b1;
        @(negedge ACLK);
        check("done_irq", 32'(irq), 32'(m_irq_en));
    endtask

    initial begin
        #500_000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          op;
        logic [5:0]  a;

        model_reset();
        repeat (3) @(negedge ACLK);
        check("rst_ready", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'(0));
        check("rst_valid", 32'({S_AXI_BVALID, S_AXI_RVALID}), 32'(0));
        check("rst_ctrl_out", 32'({vp_start, irq}), 32'(0));
        check("rst_src", vp_src_addr, 32'h0);
        ARESETN = 1'b1;
        @(negedge ACLK);
        check("ready_after_rst", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'h7);

        // SRC full write and readback
        do_write(6'h08, 32'h1000_0040, 4'hF, 0, 0, 0);
        axi_read(6'h08, 0, d, r);
        check("tp_src_rdata", d, 32'h1000_0040);
        check("tp_src_rresp", 32'(r), 32'h0);
        check("tp_src_port", vp_src_addr, 32'h1000_0040);

        // LEN partial strobe
        do_write(6'h0C, 32'hDEAD_BEEF, 4'h3, 0, 0, 1);
        axi_read(6'h0C, 1, d, r);
        check("tp_len_rdata", d, 32'h0000_BEEF);
        check("tp_len_port", 32'(vp_len), 32'h0000_BEEF);

        // W ahead of AW by three cycles
        do_write(6'h08, 32'h1234_5678, 4'hF, 3, 0, 0);
        check("tp_w_first_src", vp_src_addr, 32'h1234_5678);

        // start, done, irq, W1C
        vp_busy = 1'b0;
        do_write(6'h00, 32'h3, 4'hF, 0, 0, 0);
        check("tp_one_start", start_cnt, 1);
        pulse_done();
        axi_read(6'h04, 0, d, r);
        check("tp_status_done", d, 32'h2);
        check("tp_irq_set", 32'(irq), 32'(1));
        do_write(6'h04, 32'h2, 4'h1, 0, 0, 0);
        check("tp_irq_clr", 32'(irq), 32'(0));

        // start while busy
        @(negedge ACLK);
        vp_busy = 1'b1;
        do_write(6'h00, 32'h1, 4'hF, 0, 0, 0);
        check("tp_no_start", start_cnt, 1);
        axi_read(6'h04, 0, d, r);
        check("tp_status_err", d, 32'h5);
        @(negedge ACLK);
        vp_busy = 1'b0;
        do_write(6'h04, 32'h4, 4'h1, 0, 0, 0);
        do_read(6'h04, 0);

        // unmapped accesses
        axi_read(6'h10, 0, d, r);
        check("tp_unmapped_rdata", d, 32'h0);
        check("tp_unmapped_rresp", 32'(r), 32'h2);
        do_write(6'h30, 32'hFFFF_FFFF, 4'hF, 0, 1, 0);
        for (int i = 0; i < 4; i++) do_read(6'(4 * i), 0);

        // done pulse in the same cycle as the DONE W1C commit: set must win
        do_write(6'h00, 32'h2, 4'h1, 0, 0, 0);
        pulse_done();
        @(negedge ACLK);
        S_AXI_AWADDR  = 6'h04;
        S_AXI_WDATA   = 32'h2;
        S_AXI_WSTRB   = 4'h1;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        check("race_ready", 32'({S_AXI_AWREADY, S_AXI_WREADY}), 32'h3);
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        vp_done       = 1'b1;
        @(negedge ACLK);
        vp_done = 1'b0;
        check("race_bvalid", 32'(S_AXI_BVALID), 32'(1));
        S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_BREADY = 1'b0;
        do_read(6'h04, 0);
        check("race_irq", 32'(irq), 32'(1));

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            op = int'($urandom_range(0, 9));
            if ($urandom_range(0, 4) == 0)
                a = {2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), 2'b00};
            else
                a = {2'b00, 2'($urandom_range(0, 3)), 2'b00};
            if (op < 4) begin
                do_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            end else if (op < 8) begin
                do_read(a, int'($urandom_range(0, 2)));
            end else if (op == 8) begin
                pulse_done();
            end else begin
                @(negedge ACLK);
                vp_busy = 1'($urandom_range(0, 1));
            end
        end

        // reset in the middle of outstanding read and write responses
        @(negedge ACLK);
        S_AXI_ARADDR  = 6'h08;
        S_AXI_ARVALID = 1'b1;
        S_AXI_AWADDR  = 6'h08;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA   = 32'hA5A5_5A5A;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_WVALID  = 1'b1;
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        check("abort_rvalid_pending", 32'(S_AXI_RVALID), 32'(1));
        @(negedge ACLK);
        check("abort_bvalid_pending", 32'(S_AXI_BVALID), 32'(1));
        #2 ARESETN = 1'b0;
        #1;
        check("abort_valid_drop", 32'({S_AXI_BVALID, S_AXI_RVALID}), 32'(0));
        check("abort_src_cleared", vp_src_addr, 32'h0);
        model_reset();
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        do_read(6'h08, 0);
        do_read(6'h00, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
